// File: rtl/controller_pkg.sv
// Shared state encoding for the memory-game controller; datapath benches decode `state` with it.
package controller_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S_INIT       = 3'd0;
    localparam logic [STATE_W-1:0] S_SETUP      = 3'd1;
    localparam logic [STATE_W-1:0] S_PLAY_FPGA  = 3'd2;
    localparam logic [STATE_W-1:0] S_PLAY_USER  = 3'd3;
    localparam logic [STATE_W-1:0] S_CHECK      = 3'd4;
    localparam logic [STATE_W-1:0] S_NEXT_ROUND = 3'd5;
    localparam logic [STATE_W-1:0] S_RESULT     = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        StInit      = S_INIT,
        StSetup     = S_SETUP,
        StPlayFpga  = S_PLAY_FPGA,
        StPlayUser  = S_PLAY_USER,
        StCheck     = S_CHECK,
        StNextRound = S_NEXT_ROUND,
        StResult    = S_RESULT
    } state_e;

endpackage

// File: rtl/controller_key_edge.sv
// Two-flop synchroniser plus history flop; emits one-cycle pulse when the key is pressed.
module key_edge #(
    parameter bit ActiveLow = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic pulse_o
);

    localparam logic Released = ActiveLow;

    logic sync1_q, sync2_q, hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= Released;
            sync2_q <= Released;
            hist_q  <= Released;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // Press is a transition from the released level to the pressed level.
    always_comb begin
        if (ActiveLow) pulse_o = hist_q & ~sync2_q;
        else           pulse_o = ~hist_q & sync2_q;
    end

endmodule

// File: rtl/controller.sv
// Game-flow FSM for the memory game: sequences FPGA-show / user-repeat rounds and strobes datapath.
module controller
    import controller_pkg::*;
#(
    parameter int unsigned p_key = 4
) (
    input  logic               CLOCK_50,
    input  logic               R,
    input  logic [p_key-1:0]   KEY,
    input  logic               end_FPGA,
    input  logic               end_User,
    input  logic               end_time,
    input  logic               win,
    input  logic               match,
    output logic               R1,
    output logic               R2,
    output logic               E1,
    output logic               E2,
    output logic               E3,
    output logic               E4,
    output logic               SEL,
    output logic [STATE_W-1:0] state
);

    logic   enter_pulse;
    logic   unused_key;
    state_e state_q, state_d;

    // Only KEY[0] is consumed; the rest are tied off here.
    assign unused_key = ^KEY;

    key_edge #(
        .ActiveLow(1'b1)
    ) u_enter (
        .clk_i  (CLOCK_50),
        .rst_i  (R),
        .key_i  (KEY[0]),
        .pulse_o(enter_pulse)
    );

    always_ff @(posedge CLOCK_50) begin
        if (R) state_q <= StInit;
        else   state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        R1      = 1'b0;
        R2      = 1'b0;
        E1      = 1'b0;
        E2      = 1'b0;
        E3      = 1'b0;
        E4      = 1'b0;
        SEL     = 1'b0;
        case (state_q)
            StInit: begin
                R1      = 1'b1;
                R2      = 1'b1;
                state_d = StSetup;
            end
            StSetup: begin
                if (enter_pulse) state_d = StPlayFpga;
            end
            StPlayFpga: begin
                E3 = 1'b1;
                R2 = 1'b1;
                if (end_FPGA) state_d = StPlayUser;
            end
            StPlayUser: begin
                E2 = 1'b1;
                E4 = enter_pulse;
                // end_User has priority over a simultaneous timeout.
                if (end_User)      state_d = StCheck;
                else if (end_time) state_d = StResult;
            end
            StCheck: begin
                if (match && !win) state_d = StNextRound;
                else               state_d = StResult;
            end
            StNextRound: begin
                E1      = 1'b1;
                R2      = 1'b1;
                state_d = StPlayFpga;
            end
            StResult: begin
                SEL = 1'b1;
                if (enter_pulse) state_d = StInit;
            end
            default: state_d = StInit;
        endcase
    end

    assign state = state_q;

endmodule
